// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with configurable RAM read latency.
// Ports: clk/reset (sync, active-high); MEM_valid/MEM_allow_in stage handshake;
// mem_en/ls_op/mem_addr/store_data/exe_result/rf_wdest from EXE->MEM; dm_rdata from RAM;
// dm_addr/dm_wen/dm_wdata to RAM; MEM_over/mem_result/MEM_wdest/MEM_bypass_* to WB and forwarding;
// adel/ades/badvaddr exceptions, live only with `define MEM_UNALIGNED_EXC_EN.
module mem_stage_lsu #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_valid,
  input  logic              MEM_allow_in,
  input  logic              mem_en,
  input  logic [2:0]        ls_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       exe_result,
  input  logic [4:0]        rf_wdest,
  input  logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wen,
  output logic [31:0]       dm_wdata,
  output logic              MEM_over,
  output logic [31:0]       mem_result,
  output logic [4:0]        MEM_wdest,
  output logic              MEM_bypass_valid,
  output logic [31:0]       MEM_bypass_value,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [2:0] LAT = 3'(RD_LATENCY);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic issued_q, issued_d;
  logic [31:0] rdata_q, rdata_d;
  logic is_load, is_store, is_half, is_word, mis, fsm_load;
  logic [1:0] lane;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;
  logic [3:0] wen_raw;
  assign is_load  = mem_en & (ls_op <= 3'd4);
  assign is_store = mem_en & (ls_op >= 3'd5);
  assign is_half  = (ls_op == 3'd2) | (ls_op == 3'd3) | (ls_op == 3'd6);
  assign is_word  = (ls_op == 3'd4) | (ls_op == 3'd7);
`ifdef MEM_UNALIGNED_EXC_EN
  assign mis      = (is_half & mem_addr[0]) | (is_word & (mem_addr[1:0] != 2'd0));
  assign lane     = mem_addr[1:0];
  assign badvaddr = mem_addr;
`else
  // Without exceptions the low bits are forced to the access's natural alignment.
  assign mis      = 1'b0;
  assign lane     = is_word ? 2'd0 : is_half ? {mem_addr[1], 1'b0} : mem_addr[1:0];
  assign badvaddr = '0;
`endif
  assign byte_v  = dm_rdata[{lane, 3'b000} +: 8];
  assign half_v  = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign ld_data = (ls_op == 3'd0) ? {{24{byte_v[7]}}, byte_v} :
                   (ls_op == 3'd1) ? {24'd0, byte_v} :
                   (ls_op == 3'd2) ? {{16{half_v[15]}}, half_v} :
                   (ls_op == 3'd3) ? {16'd0, half_v} : dm_rdata;
  // Only aligned loads against a synchronous RAM need to wait for data.
  assign fsm_load = is_load & ~mis & (RD_LATENCY != 0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (MEM_allow_in) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: if (MEM_valid & fsm_load) begin
          state_d = WAIT;
          cnt_d   = 3'd1;
        end
        WAIT: if (!MEM_valid) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == LAT) begin
          state_d = DONE;
          rdata_d = ld_data;
        end else cnt_d = cnt_q + 3'd1;
        default: ;
      endcase
    end
  end
  // A store writes only in its first valid cycle; stalls must not rewrite.
  assign issued_d = MEM_allow_in ? 1'b0 : issued_q | (MEM_valid & is_store);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      issued_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      rdata_q  <= rdata_d;
    end
  end
  assign wen_raw          = is_word ? 4'b1111 : is_half ? 4'b0011 << lane : 4'b0001 << lane;
  assign dm_addr          = mem_addr;
  assign dm_wen           = (~reset & MEM_valid & is_store & ~mis & ~issued_q) ? wen_raw : 4'd0;
  assign dm_wdata         = is_word ? store_data : is_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  assign MEM_over         = ~reset & (fsm_load ? (state_q == DONE) : MEM_valid);
  assign mem_result       = is_load ? (fsm_load ? rdata_q : ld_data) : exe_result;
  assign MEM_wdest        = MEM_valid ? rf_wdest : 5'd0;
  assign MEM_bypass_valid = ~reset & MEM_valid & (~is_load | MEM_over);
  assign MEM_bypass_value = mem_result;
  assign adel             = MEM_valid & is_load & mis;
  assign ades             = MEM_valid & is_store & mis;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized bench for mem_stage_lsu at read latencies 0, 1 and 3.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic reset, MEM_valid, MEM_allow_in, mem_en;
  logic [2:0] ls_op;
  logic [31:0] mem_addr, store_data, exe_result, dm_rdata;
  logic [4:0] rf_wdest;
  logic [31:0] daddr [3], wdata [3], res [3], bval [3], bad [3];
  logic [3:0] wen [3];
  logic [4:0] wd [3];
  logic over [3], bv [3], adel [3], ades [3];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_lsu #(.RD_LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 3)), .ADDR_W(32)) u_dut (
      .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .MEM_allow_in(MEM_allow_in),
      .mem_en(mem_en), .ls_op(ls_op), .mem_addr(mem_addr), .store_data(store_data),
      .exe_result(exe_result), .rf_wdest(rf_wdest), .dm_rdata(dm_rdata),
      .dm_addr(daddr[g]), .dm_wen(wen[g]), .dm_wdata(wdata[g]), .MEM_over(over[g]),
      .mem_result(res[g]), .MEM_wdest(wd[g]), .MEM_bypass_valid(bv[g]),
      .MEM_bypass_value(bval[g]), .adel(adel[g]), .ades(ades[g]), .badvaddr(bad[g])
    );
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int op_size(logic [2:0] op);
    return (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
  endfunction
  function automatic bit op_mis(logic [2:0] op, logic [31:0] a);
`ifdef MEM_UNALIGNED_EXC_EN
    return (a % op_size(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int op_off(logic [2:0] op, logic [31:0] a);
`ifdef MEM_UNALIGNED_EXC_EN
    return int'(a % 4);
`else
    return int'(a % 4) - int'(a % 4) % op_size(op);
`endif
  endfunction
  function automatic logic [31:0] ld_model(logic [2:0] op, logic [31:0] a, logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    logic [31:0] v = (rd >> (8 * op_off(op, a))) & mask;
    if ((op == 0 || op == 2) && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
    return v;
  endfunction
  task automatic run_txn(logic [2:0] op, logic [31:0] a, logic [31:0] sd, logic [31:0] exe,
                         logic [31:0] rd, logic en, int stall);
    bit ld = en && op <= 4;
    bit st = en && op >= 5;
    bit mis = en && op_mis(op, a);
    int n = 5 + stall;
    int sz = op_size(op);
    logic [3:0] wen_m = 4'(((1 << sz) - 1) << op_off(op, a));
    logic [31:0] wd_m = (sz == 1) ? {24'd0, sd[7:0]} * 32'h0101_0101 :
                        (sz == 2) ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
    MEM_valid = 1'b1; MEM_allow_in = 1'b0; mem_en = en; ls_op = op; mem_addr = a;
    store_data = sd; exe_result = exe; dm_rdata = rd; rf_wdest = 5'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) MEM_allow_in = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        int lat = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        bit eo = (ld && !mis && lat > 0) ? (k >= lat + 1) : 1'b1;
        check($sformatf("over op%0d g%0d k%0d", op, g, k), 32'(over[g]), 32'(eo));
        check($sformatf("wen op%0d g%0d k%0d", op, g, k), 32'(wen[g]), (st && !mis && k == 0) ? 32'(wen_m) : 32'd0);
        check($sformatf("bypass_valid op%0d g%0d k%0d", op, g, k), 32'(bv[g]), 32'(!ld || eo));
        if (ld && !mis && eo) check($sformatf("load op%0d a%h g%0d", op, a, g), res[g], ld_model(op, a, rd));
        else if (!ld) check($sformatf("exe g%0d", g), bval[g], exe);
      end
      if (k == 0) begin
        if (st) check($sformatf("wdata op%0d", op), wdata[1], wd_m);
        check("adel", 32'(adel[1]), 32'(ld && mis));
        check("ades", 32'(ades[1]), 32'(st && mis));
`ifdef MEM_UNALIGNED_EXC_EN
        check("badvaddr", bad[1], a);
`else
        check("badvaddr", bad[1], 32'd0);
`endif
        check("dm_addr", daddr[2], a);
        check("wdest", 32'(wd[2]), 32'(rf_wdest));
      end
      @(posedge clk); #1;
    end
    MEM_allow_in = 1'b0;
  endtask
  task automatic bubble();
    MEM_valid = 1'b0; mem_en = 1'b1; ls_op = 3'($urandom); mem_addr = $urandom & ~32'd3;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("bubble over g%0d", g), 32'(over[g]), 32'd0);
      check($sformatf("bubble wen g%0d", g), 32'(wen[g]), 32'd0);
      check($sformatf("bubble bv g%0d", g), 32'(bv[g]), 32'd0);
    end
    check("bubble wdest", 32'(wd[0]), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    reset = 1'b1; MEM_valid = 1'b1; MEM_allow_in = 1'b0; mem_en = 1'b1; ls_op = 3'd4;
    mem_addr = 32'h10; store_data = 0; exe_result = 0; dm_rdata = 32'hDEAD_BEEF; rf_wdest = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset over g%0d", g), 32'(over[g]), 32'd0);
      check($sformatf("reset bv g%0d", g), 32'(bv[g]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bubble();
    run_txn(3'd4, 32'h10, 0, 32'h55, 32'hDEAD_BEEF, 1'b1, 0);
    run_txn(3'd0, 32'h13, 0, 0, 32'h80FF_0000, 1'b1, 0);
    run_txn(3'd1, 32'h13, 0, 0, 32'h80FF_0000, 1'b1, 1);
    run_txn(3'd2, 32'h12, 0, 0, 32'h80FF_0000, 1'b1, 0);
    run_txn(3'd6, 32'h22, 32'h1234_ABCD, 32'h77, 0, 1'b1, 3);
    run_txn(3'd4, 32'h40, 0, 0, 32'h0BAD_F00D, 1'b1, 2);
    run_txn(3'd4, 32'h44, 0, 0, 32'h1357_9BDF, 1'b1, 0);
    run_txn(3'd7, 32'h31, 32'hCAFE_0001, 0, 0, 1'b1, 0);
    run_txn(3'd3, 32'h2, 0, 0, 32'h9876_5432, 1'b1, 0);
    run_txn(3'd5, 32'h7, 32'h0000_00A5, 0, 0, 1'b1, 1);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      run_txn(3'($urandom), a, $urandom, $urandom, $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) bubble();
    end
    MEM_valid = 1'b1; mem_en = 1'b1; ls_op = 3'd4; mem_addr = 32'h80; MEM_allow_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("midreset over g%0d", g), 32'(over[g]), 32'd0);
      check($sformatf("midreset bv g%0d", g), 32'(bv[g]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postreset over lat1", 32'(over[1]), 32'd0);
    check("postreset over lat3", 32'(over[2]), 32'd0);
    @(posedge clk); #1;
    MEM_valid = 1'b0; MEM_allow_in = 1'b1;
    @(posedge clk); #1;
    MEM_allow_in = 1'b0;
    bubble();
    run_txn(3'd4, 32'h84, 0, 0, 32'h2468_ACE0, 1'b1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
